// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
//   Shares one register file between the CPU core and a debug port. The core
//   owns the regfile ports by default. A pending debug request is granted as
//   soon as the core is idle. If the core stays busy, the request is forced
//   through after STARVE_LIMIT waiting cycles. A granted access stalls the
//   core while the debug access uses the ports.
//
// Ports
//   clk, reset            : clock, synchronous active-low reset
//   core_valid            : core issues regfile accesses this cycle
//   core_regwrite/_rs1adr/_rs2adr/_rdadr/_rd : core-side regfile request
//   core_stall            : core must hold its request fields
//   dbg_req/_we/_adr/_wdata : debug access request (held until dbg_ack)
//   dbg_ack               : one-cycle completion pulse
//   dbg_rdata             : debug read data, valid with dbg_ack
//   regwrite/rs1adr/rs2adr/rdadr/rd : regfile port drive
//   rs1                   : regfile read data (one cycle after rs1adr)
// ---------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_valid,
  input  logic        core_regwrite,
  input  logic [3:0]  core_rs1adr,
  input  logic [3:0]  core_rs2adr,
  input  logic [3:0]  core_rdadr,
  input  logic [31:0] core_rd,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [3:0]  dbg_adr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        regwrite,
  output logic [3:0]  rs1adr,
  output logic [3:0]  rs2adr,
  output logic [3:0]  rdadr,
  output logic [31:0] rd,
  input  logic [31:0] rs1
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT, RDWAIT, ACK} state_t;

  state_t      r_state;
  logic [7:0]  r_starve_cnt;
  logic        r_core_stall;
  logic        r_dbg_ack;
  logic [31:0] r_dbg_rdata;
  logic        w_grant;

  // Grant immediately when the core is quiet, or once the request has waited
  // the full starvation budget.
  assign w_grant = (r_state == IDLE) && dbg_req &&
                   (!core_valid || (r_starve_cnt == LIMIT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= 8'd0;
      r_core_stall <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_dbg_rdata  <= 32'd0;
    end else begin
      r_dbg_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state      <= GRANT;
            r_core_stall <= 1'b1;
            r_starve_cnt <= 8'd0;
          end else if (!dbg_req) begin
            r_starve_cnt <= 8'd0;
          end else if (core_valid && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
          end
        end
        GRANT: begin
          // Writes commit in this cycle; reads need one more cycle for the
          // registered rs1 data to come back.
          if (dbg_we) begin
            r_state      <= ACK;
            r_core_stall <= 1'b0;
            r_dbg_ack    <= 1'b1;
          end else begin
            r_state <= RDWAIT;
          end
        end
        RDWAIT: begin
          r_dbg_rdata  <= rs1;
          r_state      <= ACK;
          r_core_stall <= 1'b0;
          r_dbg_ack    <= 1'b1;
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_core_stall <= 1'b0;
        end
      endcase
    end
  end

  // Regfile port mux: core fields pass through except during the debug slots.
  always_comb begin
    rs1adr   = core_rs1adr;
    rs2adr   = core_rs2adr;
    rdadr    = core_rdadr;
    rd       = core_rd;
    regwrite = core_regwrite & core_valid;
    case (r_state)
      GRANT: begin
        rs1adr   = dbg_adr;
        rdadr    = dbg_adr;
        rd       = dbg_wdata;
        regwrite = dbg_we;
      end
      RDWAIT:  regwrite = 1'b0;
      default: ;
    endcase
    // No regfile write may escape while reset is held.
    if (!reset) regwrite = 1'b0;
  end

  assign core_stall = r_core_stall;
  assign dbg_ack    = r_dbg_ack;
  assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_valid, core_regwrite;
  logic [3:0]  core_rs1adr, core_rs2adr, core_rdadr;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        dbg_req, dbg_we;
  logic [3:0]  dbg_adr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        regwrite;
  logic [3:0]  rs1adr, rs2adr, rdadr;
  logic [31:0] rd;
  logic [31:0] rs1;

  int checks = 0;
  int errors = 0;

  // Expected architectural register contents and last debug read value.
  logic [31:0] exp_rf [16];
  logic [31:0] last_rdata;

  // Simple register file attached to the DUT ports.
  logic [31:0] rf [16];
  logic        rf_clr;

  regfile_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .core_valid(core_valid), .core_regwrite(core_regwrite),
    .core_rs1adr(core_rs1adr), .core_rs2adr(core_rs2adr),
    .core_rdadr(core_rdadr), .core_rd(core_rd),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .regwrite(regwrite), .rs1adr(rs1adr), .rs2adr(rs2adr),
    .rdadr(rdadr), .rd(rd), .rs1(rs1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      rs1 <= 32'd0;
    end else begin
      if (regwrite && rdadr != 4'd0) rf[rdadr] <= rd;
      rs1 <= (rs1adr == 4'd0) ? 32'd0 : rf[rs1adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One debug access. Expected timing follows from the arbitration rules:
  // the grant lands one edge after the request when the core is quiet, or
  // LIM+1 edges later when the core stays busy; a write acks one cycle after
  // grant and a read two cycles after grant.
  task automatic dbg_access(input bit we, input logic [3:0] adr, input logic [31:0] wd,
                            input bit core_act, input bit drop, input bit keep);
    int g, total;
    logic [31:0] exp_rd;
    g      = core_act ? LIM + 1 : 1;
    total  = g + (we ? 1 : 2);
    exp_rd = we ? last_rdata : ((adr == 4'd0) ? 32'd0 : exp_rf[adr]);
    dbg_req = 1'b1; dbg_we = we; dbg_adr = adr; dbg_wdata = wd;
    core_valid = core_act; core_regwrite = 1'b0;
    for (int c = 1; c <= total; c++) begin
      if (core_act && c < g) begin
        core_rs1adr = 4'($urandom); core_rs2adr = 4'($urandom);
        core_rdadr  = 4'($urandom); core_rd     = $urandom;
      end
      @(posedge clk); #1;
      chk("stall", 32'(c >= g && c < total), 32'(core_stall));
      chk("ack", 32'(dbg_ack), 32'(c == total));
      if (c == g) begin
        chk("grant_regwrite", 32'(regwrite), 32'(we));
        chk("grant_rdadr", 32'(rdadr), 32'(adr));
        chk("grant_rs1adr", 32'(rs1adr), 32'(adr));
        chk("grant_rs2adr", 32'(rs2adr), 32'(core_rs2adr));
        chk("grant_rd", rd, wd);
        if (drop) dbg_req = 1'b0;
      end else begin
        chk("pass_rs1adr", 32'(rs1adr), 32'(core_rs1adr));
        chk("pass_rs2adr", 32'(rs2adr), 32'(core_rs2adr));
        chk("pass_regwrite", 32'(regwrite), 32'd0);
      end
      if (c == total) chk("ack_rdata", dbg_rdata, exp_rd);
    end
    if (!keep) dbg_req = 1'b0;
    @(posedge clk); #1;
    chk("post_stall", 32'(core_stall), 32'd0);
    chk("post_ack", 32'(dbg_ack), 32'd0);
    chk("post_rdata", dbg_rdata, exp_rd);
    if (we && adr != 4'd0) exp_rf[adr] = wd;
    last_rdata = exp_rd;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_rf[i] = 32'd0;
    last_rdata = 32'd0;
    rf_clr = 1'b1;
    reset = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = 4'd0; dbg_wdata = 32'd0;
    core_valid = 1'b1; core_regwrite = 1'b1;
    core_rs1adr = 4'd1; core_rs2adr = 4'd2; core_rdadr = 4'd4; core_rd = 32'hCAFE0001;

    // Reset behaviour
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    rf_clr = 1'b0;
    reset = 1'b1;
    core_valid = 1'b0; core_regwrite = 1'b0;
    @(posedge clk); #1;

    // Core pass-through in IDLE with random traffic
    for (int i = 0; i < 12; i++) begin
      core_valid    = 1'($urandom);
      core_regwrite = 1'($urandom);
      core_rs1adr   = 4'($urandom); core_rs2adr = 4'($urandom);
      core_rdadr    = 4'($urandom); core_rd     = $urandom;
      #2;
      chk("idle_regwrite", 32'(regwrite), 32'(core_valid & core_regwrite));
      chk("idle_rs1adr", 32'(rs1adr), 32'(core_rs1adr));
      chk("idle_rs2adr", 32'(rs2adr), 32'(core_rs2adr));
      chk("idle_rdadr", 32'(rdadr), 32'(core_rdadr));
      chk("idle_rd", rd, core_rd);
      chk("idle_stall", 32'(core_stall), 32'd0);
      if (core_valid && core_regwrite && core_rdadr != 4'd0) exp_rf[core_rdadr] = core_rd;
      @(posedge clk); #1;
    end
    core_valid = 1'b0; core_regwrite = 1'b0;

    // Write then read x5 with the core idle
    dbg_access(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    dbg_access(1'b0, 4'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("x5_readback", dbg_rdata, 32'hDEADBEEF);

    // x0 stays zero
    dbg_access(1'b1, 4'd0, 32'h12345678, 1'b0, 1'b0, 1'b0);
    dbg_access(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("x0_readback", dbg_rdata, 32'd0);

    // Starvation limit with the core permanently busy
    dbg_access(1'b0, 4'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    dbg_access(1'b1, 4'd9, $urandom, 1'b1, 1'b0, 1'b0);

    // Core write presented during a stall is only committed after the stall
    dbg_access(1'b1, 4'd3, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 4'd7; core_valid = 1'b0;
    @(posedge clk); #1;
    chk("cw_grant_stall", 32'(core_stall), 32'd1);
    core_valid = 1'b1; core_regwrite = 1'b1; core_rdadr = 4'd3; core_rd = 32'h11;
    core_rs1adr = 4'd3; core_rs2adr = 4'd2;
    #1;
    chk("cw_grant_regwrite", 32'(regwrite), 32'd0);
    chk("cw_grant_rdadr", 32'(rdadr), 32'd7);
    @(posedge clk); #1;
    chk("cw_rdwait_stall", 32'(core_stall), 32'd1);
    chk("cw_rdwait_regwrite", 32'(regwrite), 32'd0);
    @(posedge clk); #1;
    chk("cw_ack", 32'(dbg_ack), 32'd1);
    chk("cw_ack_stall", 32'(core_stall), 32'd0);
    chk("cw_ack_regwrite", 32'(regwrite), 32'd1);
    chk("cw_ack_rdadr", 32'(rdadr), 32'd3);
    chk("cw_ack_rd", rd, 32'h11);
    chk("cw_ack_rdata", dbg_rdata, exp_rf[7]);
    last_rdata = exp_rf[7];
    exp_rf[3] = 32'h11;
    dbg_req = 1'b0;
    @(posedge clk); #1;
    core_valid = 1'b0; core_regwrite = 1'b0;
    chk("cw_post_ack", 32'(dbg_ack), 32'd0);
    dbg_access(1'b0, 4'd3, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("x3_readback", dbg_rdata, 32'h11);

    // Back-to-back reads with dbg_req held high
    dbg_access(1'b0, 4'd5, 32'd0, 1'b0, 1'b0, 1'b1);
    dbg_access(1'b0, 4'd3, 32'd0, 1'b0, 1'b0, 1'b1);
    dbg_access(1'b0, 4'd9, 32'd0, 1'b0, 1'b0, 1'b0);

    // Request dropped mid-access still completes
    dbg_access(1'b0, 4'd5, 32'd0, 1'b0, 1'b1, 1'b0);
    dbg_access(1'b1, 4'd6, 32'h0BADF00D, 1'b0, 1'b1, 1'b0);

    // Reset during RDWAIT abandons the access
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 4'd5; core_valid = 1'b0;
    @(posedge clk); #1;
    chk("rr_grant_stall", 32'(core_stall), 32'd1);
    @(posedge clk); #1;
    chk("rr_rdwait_stall", 32'(core_stall), 32'd1);
    reset = 1'b0; dbg_req = 1'b0;
    core_valid = 1'b1; core_regwrite = 1'b1; core_rdadr = 4'd6; core_rd = 32'hFFFFFFFF;
    #1;
    chk("rr_regwrite", 32'(regwrite), 32'd0);
    @(posedge clk); #1;
    chk("rr_ack", 32'(dbg_ack), 32'd0);
    chk("rr_stall", 32'(core_stall), 32'd0);
    chk("rr_rdata", dbg_rdata, 32'd0);
    reset = 1'b1; core_valid = 1'b0; core_regwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rr_no_ack", 32'(dbg_ack), 32'd0);
    end
    last_rdata = 32'd0;
    // Starvation counter restarts from zero after reset
    dbg_access(1'b0, 4'd6, 32'd0, 1'b1, 1'b0, 1'b0);

    // Randomized accesses
    for (int i = 0; i < 20; i++) begin
      dbg_access(1'($urandom), 4'($urandom), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
